// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: register count,
// address width, writeback requester indices and the address decoder.
package regfile_pkg;

    localparam int REG_COUNT  = 8;
    localparam int REG_ADDR_W = 3;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_IMM  = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_COUNT-1:0]  reg_sel_t;

    function automatic reg_sel_t addr_to_onehot(input reg_addr_t addr);
        reg_sel_t sel;
        sel       = '0;
        sel[addr] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pure combinational round-robin pick: searches upward from ptr, wrapping,
// and returns the first asserted request as one-hot grant plus its index.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    int               cand;
    logic [SEL_W-1:0] cand_sel;
    logic             found;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_sel = '0;
        for (int k = 0; k < N; k++) begin
            // ptr is always below N, so one subtraction covers the wrap
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_sel = SEL_W'(cand);
            if (!found && req[cand_sel]) begin
                found         = 1'b1;
                gnt[cand_sel] = 1'b1;
                idx           = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// registered address decode. Macro REGFILE_R0_ZERO_EN makes register 0 read-only zero.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_REQ = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        hold,
    output logic                        wr_en,
    output logic [REG_COUNT-1:0]        wr_sel,
    output logic [REG_ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]           wr_data
);

    logic [REG_ADDR_W-1:0] ptr_q, ptr_d;
    logic                  wr_en_q, wr_en_d;
    reg_sel_t              wr_sel_q, wr_sel_d;
    reg_addr_t             wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [REG_ADDR_W-1:0] gnt_idx;
    logic                  hs;
    reg_addr_t             win_addr;
    logic [DATA_W-1:0]     win_data;

    assign arb_req = req_valid & {NUM_REQ{~hold}};

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (REG_ADDR_W)
    ) u_rr_arbiter (
        .req (arb_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (gnt_idx)
    );

    // Grant is suppressed combinationally during reset so no requester sees a handshake
    assign req_ready = arb_gnt & {NUM_REQ{rst_n}};
    assign hs        = |req_ready;

    assign win_addr = req_addr[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
    assign win_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (hs) begin
            ptr_d     = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 3'd1;
            wr_en_d   = 1'b1;
            wr_sel_d  = addr_to_onehot(win_addr);
            wr_addr_d = win_addr;
            wr_data_d = win_data;
`ifdef REGFILE_R0_ZERO_EN
            // r0 writes still complete the handshake but never strobe the file
            if (win_addr == '0) begin
                wr_en_d  = 1'b0;
                wr_sel_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
